// File: rtl/rsa_keygen_ctrl.sv
// RSA key-set sequencer for small primes: derives n, phi, the smallest usable e
// (checked through an external gcd engine) and d by incremental modular search.
module rsa_keygen_ctrl #(
    parameter int KW          = 4,
    parameter int W           = 8,
    parameter int E_MIN       = 3,
    parameter int GCD_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] p,
    input  logic [KW-1:0] q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  n,
    output logic [W-1:0]  phi,
    output logic [W-1:0]  e,
    output logic [W-1:0]  d,
    output logic [W-1:0]  gcd_a,
    output logic [W-1:0]  gcd_b,
    output logic          gcd_start,
    input  logic          gcd_done,
    input  logic [W-1:0]  gcd_out
);

    localparam int CW = $clog2(GCD_TIMEOUT + 1);
    localparam logic [W-1:0]  ONE    = W'(1);
    localparam logic [W-1:0]  EMIN_W = W'(E_MIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(GCD_TIMEOUT - 1);

    // gcd handshake: gcd_start is a one-cycle pulse in E_REQ; gcd_a/gcd_b are
    // held stable until gcd_done is seen in E_WAIT, which is the only state
    // that listens to gcd_done.
    typedef enum logic [2:0] {
        IDLE, SETUP, E_REQ, E_WAIT, D_INIT, D_SEARCH, DONE, ERR
    } state_t;

    state_t         state, state_n;
    logic [KW-1:0]  p_r, p_n, q_r, q_n;
    logic [W-1:0]   n_r, n_n, phi_r, phi_n, e_r, e_n, d_r, d_n, r_r, r_n;
    logic [CW-1:0]  cnt, cnt_n;

    logic [W-1:0]   pw, qw, n_calc, phi_calc, r_next;
    logic [W:0]     e_inc, r_sum, r_red;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p_r   <= '0;
            q_r   <= '0;
            n_r   <= '0;
            phi_r <= '0;
            e_r   <= '0;
            d_r   <= '0;
            r_r   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            p_r   <= p_n;
            q_r   <= q_n;
            n_r   <= n_n;
            phi_r <= phi_n;
            e_r   <= e_n;
            d_r   <= d_n;
            r_r   <= r_n;
            cnt   <= cnt_n;
        end
    end

    // Datapath arithmetic; sums kept at W+1 bits so r+e cannot wrap.
    always_comb begin
        pw       = W'(p_r);
        qw       = W'(q_r);
        n_calc   = pw * qw;
        phi_calc = (pw - ONE) * (qw - ONE);
        e_inc    = {1'b0, e_r} + (W+1)'(1);
        r_sum    = {1'b0, r_r} + {1'b0, e_r};
        r_red    = (r_sum >= {1'b0, phi_r}) ? (r_sum - {1'b0, phi_r}) : r_sum;
        r_next   = r_red[W-1:0];
    end

    always_comb begin
        state_n = state;
        p_n     = p_r;
        q_n     = q_r;
        n_n     = n_r;
        phi_n   = phi_r;
        e_n     = e_r;
        d_n     = d_r;
        r_n     = r_r;
        cnt_n   = cnt;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    p_n     = p;
                    q_n     = q;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                n_n   = n_calc;
                phi_n = phi_calc;
                e_n   = EMIN_W;
                d_n   = '0;
                if (p_r < KW'(2) || q_r < KW'(2) || phi_calc <= EMIN_W)
                    state_n = ERR;
                else
                    state_n = E_REQ;
            end
            E_REQ: begin
                cnt_n   = '0;
                state_n = E_WAIT;
            end
            E_WAIT: begin
                if (gcd_done) begin
                    if (gcd_out == ONE) begin
                        state_n = D_INIT;
                    end else if (e_inc >= {1'b0, phi_r}) begin
                        d_n     = '0;
                        state_n = ERR;
                    end else begin
                        e_n     = e_inc[W-1:0];
                        state_n = E_REQ;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        d_n     = '0;
                        state_n = ERR;
                    end
                end
            end
            D_INIT: begin
                d_n     = ONE;
                r_n     = e_r;
                state_n = D_SEARCH;
            end
            D_SEARCH: begin
                // r tracks d*e mod phi, so r == 1 means d is the inverse.
                if (r_r == ONE) begin
                    state_n = DONE;
                end else if (d_r == phi_r - ONE) begin
                    d_n     = '0;
                    state_n = ERR;
                end else begin
                    d_n = d_r + ONE;
                    r_n = r_next;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign gcd_start = (state == E_REQ);
    assign n         = n_r;
    assign phi       = phi_r;
    assign e         = e_r;
    assign d         = d_r;
    assign gcd_a     = phi_r;
    assign gcd_b     = e_r;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Directed bench for rsa_keygen_ctrl with a latency-3 gcd engine model and
// hand-computed key sets, error paths, timeout and reset robustness.
module tb_rsa_keygen_ctrl;

    localparam int G = 3;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] p, q;
    logic       busy, done, err, gcd_start, gcd_done;
    logic [7:0] n, phi, e, d, gcd_a, gcd_b, gcd_out;

    logic       model_done = 1'b0;
    logic [7:0] model_out  = 8'd0;
    logic       stray_done;
    logic       mute;
    int         lat = 0;
    logic [7:0] ga = 0, gb = 0;
    int         starts_seen = 0;
    int         unstable = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_a;

    int vec_cnt = 0;
    int err_cnt = 0;

    assign gcd_done = model_done | stray_done;
    assign gcd_out  = stray_done ? 8'd1 : model_out;

    always #5 clk = ~clk;

    rsa_keygen_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .p(p), .q(q),
        .busy(busy), .done(done), .err(err),
        .n(n), .phi(phi), .e(e), .d(d),
        .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_start(gcd_start),
        .gcd_done(gcd_done), .gcd_out(gcd_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gcd_f(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // gcd engine model: answers G cycles after the gcd_start cycle.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (rst) begin
            lat = 0;
        end else begin
            if (lat > 0) begin
                if (gcd_a != ga || gcd_b != gb) unstable++;
                lat--;
                if (lat == 0) begin
                    model_done = 1'b1;
                    model_out  = gcd_f(ga, gb);
                end
            end
            if (gcd_start) begin
                starts_seen++;
                if (!mute) begin
                    lat = G;
                    ga  = gcd_a;
                    gb  = gcd_b;
                end
                if (exp_q.size() > 0) begin
                    check("gcd_b_seq", gcd_b, exp_q.pop_front());
                    check("gcd_a_seq", gcd_a, exp_a);
                end
            end
        end
    end

    task automatic pulse_start(input logic [3:0] pp, input logic [3:0] qq);
        @(negedge clk);
        start = 1'b1;
        p     = pp;
        q     = qq;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cyc);
        cyc = 0;
        while (!(done || err) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!(done || err)) check("end_wait_expired", 32'(done | err), 32'd1);
    endtask

    task automatic keygen_case(input string tag, input logic [3:0] pp, input logic [3:0] qq,
                               input logic [7:0] en, input logic [7:0] ephi,
                               input logic [7:0] ee, input logic [7:0] ed,
                               input int k, input bit poke_busy);
        int cyc;
        int pre;
        pre         = 0;
        starts_seen = 0;
        unstable    = 0;
        pulse_start(pp, qq);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        if (poke_busy) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            p     = 4'd2;
            q     = 4'd3;
            @(negedge clk);
            start = 1'b0;
            pre   = 5;
            check({tag, "_busy_poke"}, 32'(busy), 32'd1);
        end
        wait_end(2000, cyc);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_n"}, 32'(n), 32'(en));
        check({tag, "_phi"}, 32'(phi), 32'(ephi));
        check({tag, "_e"}, 32'(e), 32'(ee));
        check({tag, "_d"}, 32'(d), 32'(ed));
        check({tag, "_gcd_calls"}, 32'(starts_seen), 32'(k));
        check({tag, "_gcd_stable"}, 32'(unstable), 32'd0);
        check({tag, "_latency"}, 32'(pre + cyc + 1), 32'(2 + k * (G + 1) + 1 + int'(ed)));
        @(negedge clk);
        check({tag, "_done_hold"}, 32'(done), 32'd1);
        check({tag, "_d_hold"}, 32'(d), 32'(ed));
    endtask

    initial begin
        int cnt;
        rst        = 1'b1;
        start      = 1'b0;
        p          = 4'd0;
        q          = 4'd0;
        mute       = 1'b0;
        stray_done = 1'b0;
        exp_a      = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_n", 32'(n), 32'd0);
        check("rst_phi", 32'(phi), 32'd0);
        check("rst_e", 32'(e), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_gcd_a", 32'(gcd_a), 32'd0);
        check("rst_gcd_b", 32'(gcd_b), 32'd0);
        check("rst_gcd_start", 32'(gcd_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray gcd_done while idle.
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_done", 32'(done), 32'd0);
        check("stray_err", 32'(err), 32'd0);
        check("stray_e", 32'(e), 32'd0);

        keygen_case("k5x11", 4'd5, 4'd11, 8'd55, 8'd40, 8'd3, 8'd27, 1, 1'b0);

        exp_a = 8'd12;
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd5);
        keygen_case("k3x7", 4'd3, 4'd7, 8'd21, 8'd12, 8'd5, 8'd5, 3, 1'b0);
        check("k3x7_seq_left", 32'(exp_q.size()), 32'd0);

        keygen_case("k13x11", 4'd13, 4'd11, 8'd143, 8'd120, 8'd7, 8'd103, 5, 1'b1);

        // phi too small: ERR two cycles after start, no gcd call.
        starts_seen = 0;
        pulse_start(4'd2, 4'd3);
        check("small_err_early", 32'(err), 32'd0);
        @(negedge clk);
        check("small_err", 32'(err), 32'd1);
        check("small_done", 32'(done), 32'd0);
        check("small_busy", 32'(busy), 32'd0);
        check("small_n", 32'(n), 32'd6);
        check("small_phi", 32'(phi), 32'd2);
        check("small_d", 32'(d), 32'd0);
        check("small_gcd_calls", 32'(starts_seen), 32'd0);

        // Silent gcd engine: timeout.
        mute        = 1'b1;
        starts_seen = 0;
        pulse_start(4'd5, 4'd11);
        @(negedge clk);
        @(negedge clk);
        check("to_busy", 32'(busy), 32'd1);
        cnt = 0;
        while (!err && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles", 32'(cnt), 32'd255);
        check("to_err", 32'(err), 32'd1);
        check("to_done", 32'(done), 32'd0);
        check("to_e", 32'(e), 32'd3);
        check("to_d", 32'(d), 32'd0);
        check("to_n", 32'(n), 32'd55);
        check("to_phi", 32'(phi), 32'd40);
        check("to_gcd_calls", 32'(starts_seen), 32'd1);
        mute = 1'b0;

        keygen_case("rerun", 4'd5, 4'd11, 8'd55, 8'd40, 8'd3, 8'd27, 1, 1'b0);

        // Reset in the middle of the d search.
        pulse_start(4'd5, 4'd11);
        repeat (6) @(negedge clk);
        check("ds_d_first", 32'(d), 32'd1);
        repeat (5) @(negedge clk);
        check("ds_d", 32'(d), 32'd6);
        check("ds_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ds_rst_busy", 32'(busy), 32'd0);
        check("ds_rst_done", 32'(done), 32'd0);
        check("ds_rst_err", 32'(err), 32'd0);
        check("ds_rst_n", 32'(n), 32'd0);
        check("ds_rst_phi", 32'(phi), 32'd0);
        check("ds_rst_e", 32'(e), 32'd0);
        check("ds_rst_d", 32'(d), 32'd0);
        check("ds_rst_gcd_a", 32'(gcd_a), 32'd0);
        check("ds_rst_gcd_b", 32'(gcd_b), 32'd0);
        check("ds_rst_gcd_start", 32'(gcd_start), 32'd0);
        @(negedge clk);
        check("ds_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rsa_keygen_ctrl.md
Name: rsa_keygen_ctrl

Overview:
Sequencer that derives a 4-bit-prime RSA key set (n, phi, e, d) from primes p and q. It drives the team's iterative gcd engine through a start/done handshake to select the smallest public exponent e ≥ E_MIN that is coprime to phi. It then finds d by incremental modular search. It sits between the key-entry front end and the encoder/decoder datapath, and owns the only gcd engine instance.

Parameters:
KW, 4, width of p and q.
W, 8, internal and output width (2*KW).
E_MIN, 3, first candidate public exponent.
GCD_TIMEOUT, 255, maximum cycles to wait for gcd_done before flagging an error.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to generate a key from p, q.
p  in  KW  prime p; sampled on an accepted start.
q  in  KW  prime q; sampled on an accepted start.
busy  out  1  high from the cycle after an accepted start until done or err.
done  out  1  key valid; held high until the next accepted start.
err  out  1  key generation failed; held high until the next accepted start.
n  out  W  p*q.
phi  out  W  (p-1)*(q-1).
e  out  W  public exponent.
d  out  W  private exponent.
gcd_a  out  W  gcd operand A; always equals phi.
gcd_b  out  W  gcd operand B; always equals the current e candidate.
gcd_start  out  1  one-cycle pulse launching a gcd computation.
gcd_done  in  1  gcd engine result valid.
gcd_out  in  W  gcd result.

Behaviour:
- Reset: state IDLE. All outputs 0, including busy, done, err, n, phi, e, d, gcd_a, gcd_b and gcd_start. The timeout counter is cleared.
- Reset mid-operation aborts immediately. Any later gcd_done is ignored, because it arrives in IDLE.
- start is accepted only in IDLE, DONE or ERR. It is ignored while busy.
- An accepted start clears done and err, latches p and q, and moves to SETUP.
- SETUP (1 cycle): register n = p*q and phi = (p-1)*(q-1), both W-bit unsigned; set e = E_MIN.
  - If p < 2, q < 2, or phi ≤ E_MIN, go to ERR.
  - Otherwise go to E_REQ.
- E_REQ (1 cycle): assert gcd_start for exactly this cycle, with gcd_a = phi and gcd_b = e. Clear the timeout counter and go to E_WAIT.
- E_WAIT: gcd_a and gcd_b are held stable. The counter increments each cycle that gcd_done is low.
  - Counter reaches GCD_TIMEOUT: go to ERR.
  - gcd_done high and gcd_out == 1: go to D_INIT.
  - gcd_done high and gcd_out != 1: compute e+1. If e+1 ≥ phi, go to ERR; otherwise set e = e+1 and go to E_REQ.
  - gcd_done is ignored in every state except E_WAIT.
- D_INIT (1 cycle): d = 1, r = e. Since e < phi, r < phi.
- D_SEARCH (1 candidate per cycle):
  - If r == 1, go to DONE. d holds the result.
  - Else, if d == phi-1, go to ERR.
  - Else d = d+1 and r = r+e; if that sum ≥ phi, subtract phi. The sum is evaluated at W+1 bits so there is no overflow. A single subtraction suffices.
- DONE: done = 1, busy = 0. n, phi, e and d hold until the next accepted start.
- ERR: err = 1, busy = 0.
  - n and phi hold the computed values.
  - e holds the last candidate.
  - d = 0.
- Primality of p and q is not checked. A non-coprime pair for which no exponent is found ends in ERR.
- Latency with a gcd engine of latency G per call: 2 + k*(G+1) + 1 + d cycles from start to done, where k is the number of e candidates tried.

Test Plan:
- p=5, q=11, start pulse, gcd model latency 3 → n=55, phi=40, e=3 (one gcd_start pulse), d=27, done=1, err=0.
- p=3, q=7 → gcd calls with b=3,4,5 (gcd_out=3,4,1). Result e=5, d=5, n=21, phi=12, done=1. Exactly 3 gcd_start pulses; gcd_a=12 throughout.
- p=13, q=11 → phi=120, e=7 after 5 gcd calls, d=103, n=143.
- p=2, q=3 → phi=2 ≤ E_MIN: err=1 two cycles after start, no gcd_start pulse, done=0.
- gcd model never asserts gcd_done → err=1 exactly GCD_TIMEOUT cycles after the first cycle in E_WAIT. A new start with a responsive model (p=5, q=11) then yields done with e=3, d=27.
- Robustness:
  - Assert start again while busy: ignored, operands unchanged.
  - Assert rst during D_SEARCH: next cycle all outputs 0.
  - A stray gcd_done in IDLE has no effect.
